// File: rtl/cam_axis_pkg.sv
// Shared types and constants for the camera-to-AXI4-Stream capture path.
package cam_axis_pkg;

  typedef enum logic [1:0] {
    WAIT_VS,
    CAPTURE,
    SKIP,
    DROP
  } cap_state_t;

  localparam int TDATA_W = 32;

  // FIFO entry layout is {tuser, tlast, pixel}: tuser at PIX_W+1, tlast at PIX_W.
  localparam int CTRL_W = 2;

endpackage

// File: rtl/axis_fwft_fifo.sv
// First-word fall-through FIFO: dout is valid whenever empty=0, write-to-read latency 1 cycle.
// Push while full is accepted only if a pop frees the slot in the same cycle; otherwise it is ignored.
module axis_fwft_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cam_to_axis.sv
// Camera parallel bus to AXI4-Stream video; pixel reaches m_axis 2 cycles after it is on cam_*.
// tready stalls drain the FIFO only; a pixel arriving with the FIFO full drops the rest of the frame.
module cam_to_axis
  import cam_axis_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int PIX_W      = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               cap_en,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic               cam_pix_valid,
  input  logic [PIX_W-1:0]   cam_data,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               ovf_err,
  output logic               geom_err
);

  localparam int COL_W   = $clog2(IMG_W + 1);
  localparam int ROW_W   = $clog2(IMG_H + 1);
  localparam int ENTRY_W = PIX_W + CTRL_W;

  localparam logic [COL_W-1:0] COL_LIM  = COL_W'(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(IMG_H);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic             cap_en_q;
  logic             vs_q;
  logic             vs_d;
  logic             href_q;
  logic             href_d;
  logic             pv_q;
  logic [PIX_W-1:0] data_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cap_en_q <= 1'b0;
      vs_q     <= 1'b0;
      vs_d     <= 1'b0;
      href_q   <= 1'b0;
      href_d   <= 1'b0;
      pv_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      cap_en_q <= cap_en;
      vs_q     <= cam_vsync;
      vs_d     <= vs_q;
      href_q   <= cam_href;
      href_d   <= href_q;
      pv_q     <= cam_pix_valid;
      data_q   <= cam_data;
    end
  end

  cap_state_t       state;
  cap_state_t       state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             long_line;

  logic             vs_fall;
  logic             href_fall;
  logic             pix_in;
  logic             accept;
  logic             last_pix;
  logic             full;
  logic             empty;
  logic             pop;
  logic [ENTRY_W-1:0] din;
  logic [ENTRY_W-1:0] dout;

  assign vs_fall   = vs_d && !vs_q;
  assign href_fall = href_d && !href_q;
  assign pix_in    = href_q && pv_q;
  assign accept    = (state == CAPTURE) && pix_in && (col < COL_LIM) && (row < ROW_LIM);
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  assign din       = {(row == '0) && (col == '0), col == COL_LAST, data_q};

  logic       pos_clr;
  logic       line_end;
  logic       push;
  logic       frame_done;
  logic       ovf;
  logic       geom;
  logic [1:0] drop_inc;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= WAIT_VS;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pos_clr    = 1'b0;
    line_end   = 1'b0;
    push       = 1'b0;
    frame_done = 1'b0;
    ovf        = 1'b0;
    geom       = 1'b0;
    drop_inc   = 2'd0;
    if (vs_fall) begin
      pos_clr = 1'b1;
      // A new frame arriving mid-capture closes the current one as short.
      if (state == CAPTURE) begin
        geom     = 1'b1;
        drop_inc = drop_inc + 2'd1;
      end
      if (cap_en_q) begin
        state_nxt = CAPTURE;
      end else begin
        state_nxt = SKIP;
        drop_inc  = drop_inc + 2'd1;
      end
    end else if (state == CAPTURE) begin
      if (accept) begin
        if (full && !pop) begin
          ovf       = 1'b1;
          drop_inc  = 2'd1;
          state_nxt = DROP;
        end else begin
          push = 1'b1;
          if (last_pix) begin
            frame_done = 1'b1;
            state_nxt  = WAIT_VS;
          end
        end
      end
      if (href_fall) begin
        line_end = 1'b1;
        geom     = ((col != '0) && (col < COL_LIM)) || long_line;
      end
    end
  end

  // col saturates at IMG_W; any further pixel on the line marks it long.
  always_ff @(posedge aclk) begin
    if (!aresetn || pos_clr) begin
      col       <= '0;
      row       <= '0;
      long_line <= 1'b0;
    end else if (state == CAPTURE) begin
      if (line_end) begin
        if (col != '0 && row < ROW_LIM) row <= row + ROW_W'(1);
        col       <= '0;
        long_line <= 1'b0;
      end else if (pix_in) begin
        if (col < COL_LIM) col <= col + COL_W'(1);
        else               long_line <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
      ovf_err   <= 1'b0;
      geom_err  <= 1'b0;
    end else begin
      frame_cnt <= frame_cnt + CNT_W'(frame_done);
      drop_cnt  <= drop_cnt + CNT_W'(drop_inc);
      ovf_err   <= ovf;
      geom_err  <= geom;
    end
  end

  axis_fwft_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .din     (din),
    .full    (full),
    .pop     (pop),
    .dout    (dout),
    .empty   (empty)
  );

  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : TDATA_W'(dout[PIX_W-1:0]);
  assign m_axis_tlast  = !empty && dout[PIX_W];
  assign m_axis_tuser  = !empty && dout[PIX_W+1];

endmodule
